// File: rtl/hazard_ctrl_sb.sv
// ============================================================================
// Module      : hazard_ctrl_sb
// Description : ID-stage hazard unit. It generates stall, flush and operand
//               forwarding selects, and holds a multi-cycle result scoreboard
//               and saturating performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl_sb #(
    parameter int REG_AW     = 5,
    parameter int LOAD_STALL = 1,
    parameter int LA_STALL   = 3,
    parameter int CNT_W      = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [REG_AW-1:0] rs1_ID,
    input  logic [REG_AW-1:0] rs2_ID,
    input  logic              rs1_used_ID,
    input  logic              rs2_used_ID,
    input  logic [REG_AW-1:0] rd_EX,
    input  logic              regwrite_EX,
    input  logic              load_EX,
    input  logic [REG_AW-1:0] rd_MEM,
    input  logic              regwrite_MEM,
    input  logic              auipc_MEM,
    input  logic [REG_AW-1:0] rd_WB,
    input  logic              regwrite_WB,
    input  logic              branch_ID,
    input  logic              branch_taken,
    input  logic              mc_issue,
    input  logic [REG_AW-1:0] mc_rd,
    input  logic              mc_done,
    input  logic [REG_AW-1:0] mc_done_rd,
    input  logic              perf_clear,
    output logic              stall_IFID,
    output logic              stall_IDEX,
    output logic              flush,
    output logic [1:0]        fwd_rs1_sel,
    output logic [1:0]        fwd_rs2_sel,
    output logic [31:0]       stall_output,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_count,
    output logic              sb_busy
);

    localparam int          c_sb_n       = 2 ** REG_AW;
    localparam logic [2:0]  c_load_init  = 3'(LOAD_STALL - 1);
    localparam logic [2:0]  c_la_init    = 3'(LA_STALL - 1);
    localparam logic [31:0] c_code_none  = 32'h0;
    localparam logic [31:0] c_code_lu    = 32'h1;
    localparam logic [31:0] c_code_la    = 32'hA;
    localparam logic [31:0] c_code_br    = 32'hB;
    localparam logic [31:0] c_code_sb    = 32'hC;
    localparam logic [31:0] c_code_flush = 32'hF;

    logic [2:0]        r_stall_cnt;
    logic [2:0]        w_stall_cnt_nxt;
    logic [c_sb_n-1:0] r_sb;
    logic [c_sb_n-1:0] w_sb_set;
    logic [c_sb_n-1:0] w_sb_clr;
    logic [CNT_W-1:0]  r_stall_cycles;
    logic [CNT_W-1:0]  r_flush_count;
    logic              w_lu;
    logic              w_sbh;
    logic              w_any_stall;

    // x0 is hardwired, so it can never be a producer of a hazard or a bypass.
    function automatic logic src_match(input logic              used,
                                       input logic [REG_AW-1:0] rs,
                                       input logic [REG_AW-1:0] rd,
                                       input logic              we);
        return used && we && (rs == rd) && (rd != '0);
    endfunction

    always_comb begin
        w_lu  = load_EX && (src_match(rs1_used_ID, rs1_ID, rd_EX, regwrite_EX) ||
                            src_match(rs2_used_ID, rs2_ID, rd_EX, regwrite_EX));
        w_sbh = (rs1_used_ID && (rs1_ID != '0) && r_sb[rs1_ID]) ||
                (rs2_used_ID && (rs2_ID != '0) && r_sb[rs2_ID]);
    end

    always_comb begin
        stall_IFID   = 1'b0;
        stall_IDEX   = 1'b0;
        flush        = 1'b0;
        stall_output = c_code_none;
        if (branch_taken) begin
            flush        = 1'b1;
            stall_output = c_code_flush;
        end else if (auipc_MEM) begin
            stall_IFID   = 1'b1;
            stall_IDEX   = 1'b1;
            stall_output = c_code_la;
        end else if (w_lu || (r_stall_cnt != 3'd0)) begin
            stall_IFID   = 1'b1;
            stall_IDEX   = 1'b1;
            stall_output = c_code_lu;
        end else if (w_sbh) begin
            stall_IFID   = 1'b1;
            stall_IDEX   = 1'b1;
            stall_output = c_code_sb;
        end else if (branch_ID) begin
            stall_IFID   = 1'b1;
            stall_output = c_code_br;
        end
    end

    always_comb begin
        fwd_rs1_sel = 2'b00;
        fwd_rs2_sel = 2'b00;
        if (src_match(rs1_used_ID, rs1_ID, rd_MEM, regwrite_MEM))
            fwd_rs1_sel = 2'b01;
        else if (src_match(rs1_used_ID, rs1_ID, rd_WB, regwrite_WB))
            fwd_rs1_sel = 2'b10;
        if (src_match(rs2_used_ID, rs2_ID, rd_MEM, regwrite_MEM))
            fwd_rs2_sel = 2'b01;
        else if (src_match(rs2_used_ID, rs2_ID, rd_WB, regwrite_WB))
            fwd_rs2_sel = 2'b10;
    end

    // New events reload rather than accumulate; the larger length wins.
    always_comb begin
        w_stall_cnt_nxt = r_stall_cnt;
        if (branch_taken)
            w_stall_cnt_nxt = 3'd0;
        else if (w_lu && auipc_MEM)
            w_stall_cnt_nxt = (c_load_init > c_la_init) ? c_load_init : c_la_init;
        else if (w_lu)
            w_stall_cnt_nxt = c_load_init;
        else if (auipc_MEM)
            w_stall_cnt_nxt = c_la_init;
        else if (r_stall_cnt != 3'd0)
            w_stall_cnt_nxt = r_stall_cnt - 3'd1;
    end

    // Set is OR-ed in after the clear so a same-index issue/done keeps the bit.
    always_comb begin
        w_sb_set = '0;
        w_sb_clr = '0;
        if (mc_issue && !flush && (mc_rd != '0))
            w_sb_set[mc_rd] = 1'b1;
        if (mc_done && (mc_done_rd != '0))
            w_sb_clr[mc_done_rd] = 1'b1;
    end

    assign w_any_stall = stall_IFID | stall_IDEX;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_stall_cnt    <= 3'd0;
            r_sb           <= '0;
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            r_stall_cnt <= w_stall_cnt_nxt;
            r_sb        <= (r_sb & ~w_sb_clr) | w_sb_set;
            if (perf_clear) begin
                r_stall_cycles <= '0;
                r_flush_count  <= '0;
            end else begin
                if (w_any_stall && (r_stall_cycles != '1))
                    r_stall_cycles <= r_stall_cycles + 1'b1;
                if (flush && (r_flush_count != '1))
                    r_flush_count <= r_flush_count + 1'b1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
    assign sb_busy      = |r_sb;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl_sb.sv
// ============================================================================
// Module      : tb_hazard_ctrl_sb
// Description : Directed scoreboard bench for hazard_ctrl_sb.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl_sb;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;

    localparam int K_STL  = 0;   // {stall_IFID, stall_IDEX, flush}
    localparam int K_CODE = 1;
    localparam int K_FWD1 = 2;
    localparam int K_FWD2 = 3;
    localparam int K_SC   = 4;
    localparam int K_FC   = 5;
    localparam int K_BUSY = 6;

    typedef struct {
        string       tag;
        int          kind;
        logic [31:0] val;
    } exp_t;

    logic              clock = 1'b0;
    logic              reset;
    logic [REG_AW-1:0] rs1_ID, rs2_ID, rd_EX, rd_MEM, rd_WB, mc_rd, mc_done_rd;
    logic              rs1_used_ID, rs2_used_ID, regwrite_EX, load_EX;
    logic              regwrite_MEM, auipc_MEM, regwrite_WB;
    logic              branch_ID, branch_taken, mc_issue, mc_done, perf_clear;
    logic              stall_IFID, stall_IDEX, flush, sb_busy;
    logic [1:0]        fwd_rs1_sel, fwd_rs2_sel;
    logic [31:0]       stall_output;
    logic [CNT_W-1:0]  stall_cycles, flush_count;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    hazard_ctrl_sb #(.REG_AW(REG_AW), .LOAD_STALL(2), .LA_STALL(3), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
        .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID),
        .rd_EX(rd_EX), .regwrite_EX(regwrite_EX), .load_EX(load_EX),
        .rd_MEM(rd_MEM), .regwrite_MEM(regwrite_MEM), .auipc_MEM(auipc_MEM),
        .rd_WB(rd_WB), .regwrite_WB(regwrite_WB),
        .branch_ID(branch_ID), .branch_taken(branch_taken),
        .mc_issue(mc_issue), .mc_rd(mc_rd), .mc_done(mc_done), .mc_done_rd(mc_done_rd),
        .perf_clear(perf_clear),
        .stall_IFID(stall_IFID), .stall_IDEX(stall_IDEX), .flush(flush),
        .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
        .stall_output(stall_output), .stall_cycles(stall_cycles),
        .flush_count(flush_count), .sb_busy(sb_busy)
    );

    always #5 clock = ~clock;

    task automatic push(input string tag, input int kind, input logic [31:0] val);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.val  = val;
        q.push_back(e);
    endtask

    task automatic exp_stall(input string tag, input logic [2:0] stl, input logic [31:0] code);
        push(tag, K_STL, {29'd0, stl});
        push(tag, K_CODE, code);
    endtask

    task automatic check_now();
        exp_t        e;
        logic [31:0] obs;
        while (q.size() > 0) begin
            e = q.pop_front();
            case (e.kind)
                K_STL:   obs = {29'd0, stall_IFID, stall_IDEX, flush};
                K_CODE:  obs = stall_output;
                K_FWD1:  obs = {30'd0, fwd_rs1_sel};
                K_FWD2:  obs = {30'd0, fwd_rs2_sel};
                K_SC:    obs = {28'd0, stall_cycles};
                K_FC:    obs = {28'd0, flush_count};
                default: obs = {31'd0, sb_busy};
            endcase
            total++;
            assert (obs === e.val) else begin
                bad++;
                $error("FAIL %s kind=%0d observed=%0h expected=%0h", e.tag, e.kind, obs, e.val);
            end
        end
    endtask

    // Compare at the falling edge, then advance past the next rising edge.
    task automatic cyc();
        @(negedge clock);
        check_now();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        rs1_ID = '0; rs2_ID = '0; rs1_used_ID = 0; rs2_used_ID = 0;
        rd_EX = '0; regwrite_EX = 0; load_EX = 0;
        rd_MEM = '0; regwrite_MEM = 0; auipc_MEM = 0;
        rd_WB = '0; regwrite_WB = 0;
        branch_ID = 0; branch_taken = 0;
        mc_issue = 0; mc_rd = '0; mc_done = 0; mc_done_rd = '0;
        perf_clear = 0;
    endtask

    task automatic set_lu(input logic [REG_AW-1:0] rd, input logic [REG_AW-1:0] rs);
        load_EX = 1; regwrite_EX = 1; rd_EX = rd; rs1_ID = rs; rs1_used_ID = 1;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // Reset state with idle inputs
        exp_stall("reset_stall", 3'b000, 32'h0);
        push("reset_sc", K_SC, 0);
        push("reset_fc", K_FC, 0);
        push("reset_busy", K_BUSY, 0);
        push("reset_fwd1", K_FWD1, 0);
        push("reset_fwd2", K_FWD2, 0);
        cyc();

        // Load-use: two stall cycles starting at detection
        set_lu(5, 5);
        exp_stall("lu_c0", 3'b110, 32'h1);
        cyc();
        idle();
        exp_stall("lu_c1", 3'b110, 32'h1);
        push("lu_sc1", K_SC, 1);
        cyc();
        exp_stall("lu_c2", 3'b000, 32'h0);
        push("lu_sc2", K_SC, 2);
        cyc();
        set_lu(0, 0);
        exp_stall("lu_x0", 3'b000, 32'h0);
        cyc();
        idle();
        perf_clear = 1;
        cyc();
        idle();
        push("clr_sc", K_SC, 0);
        cyc();

        // auipc in MEM: three stall cycles
        auipc_MEM = 1;
        exp_stall("la_c0", 3'b110, 32'hA);
        cyc();
        idle();
        exp_stall("la_c1", 3'b110, 32'h1);
        cyc();
        exp_stall("la_c2", 3'b110, 32'h1);
        cyc();
        exp_stall("la_c3", 3'b000, 32'h0);
        push("la_sc", K_SC, 3);
        cyc();
        perf_clear = 1;
        cyc();
        idle();

        // auipc interrupted by a taken branch in its second cycle
        auipc_MEM = 1;
        exp_stall("lab_c0", 3'b110, 32'hA);
        cyc();
        idle();
        branch_taken = 1;
        exp_stall("lab_flush", 3'b001, 32'hF);
        cyc();
        idle();
        exp_stall("lab_after", 3'b000, 32'h0);
        push("lab_sc", K_SC, 1);
        push("lab_fc", K_FC, 1);
        cyc();
        branch_ID = 1;
        exp_stall("branch_id", 3'b100, 32'hB);
        cyc();
        idle();

        // Scoreboard: set, visible next cycle, released the cycle after done
        mc_issue = 1; mc_rd = 7;
        push("sb_issue_busy", K_BUSY, 0);
        cyc();
        idle();
        rs2_ID = 7; rs2_used_ID = 1;
        exp_stall("sb_hit", 3'b110, 32'hC);
        push("sb_busy", K_BUSY, 1);
        cyc();
        mc_done = 1; mc_done_rd = 7;
        exp_stall("sb_done_nobypass", 3'b110, 32'hC);
        cyc();
        mc_done = 0;
        exp_stall("sb_released", 3'b000, 32'h0);
        push("sb_clear_busy", K_BUSY, 0);
        cyc();
        mc_issue = 1; mc_rd = 7; mc_done = 1; mc_done_rd = 7;
        exp_stall("sb_same_c0", 3'b000, 32'h0);
        cyc();
        mc_issue = 0; mc_done = 0;
        exp_stall("sb_same_set_wins", 3'b110, 32'hC);
        cyc();
        mc_done = 1; mc_done_rd = 7;
        cyc();
        idle();
        push("sb_empty", K_BUSY, 0);
        cyc();
        mc_issue = 1; mc_rd = 9; branch_taken = 1;
        cyc();
        idle();
        push("sb_flush_issue", K_BUSY, 0);
        cyc();

        // Forwarding priorities
        rd_MEM = 3; regwrite_MEM = 1; rd_WB = 3; regwrite_WB = 1;
        rs1_ID = 3; rs1_used_ID = 1;
        push("fwd_mem", K_FWD1, 1);
        cyc();
        regwrite_MEM = 0;
        push("fwd_wb", K_FWD1, 2);
        cyc();
        rs1_used_ID = 0;
        push("fwd_unused", K_FWD1, 0);
        cyc();
        rs2_ID = 0; rs2_used_ID = 1; rd_WB = 0;
        push("fwd_x0", K_FWD2, 0);
        cyc();
        rs2_ID = 4; rd_WB = 4;
        push("fwd2_wb", K_FWD2, 2);
        cyc();
        idle();

        // Asynchronous reset mid-stall
        set_lu(6, 6);
        cyc();
        idle();
        #2;
        reset = 1'b1;
        #1;
        exp_stall("rst_async", 3'b000, 32'h0);
        push("rst_sc", K_SC, 0);
        push("rst_fc", K_FC, 0);
        check_now();
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Counter saturation and clear
        set_lu(8, 8);
        repeat (20) cyc();
        push("sat_sc", K_SC, 15);
        cyc();
        idle();
        perf_clear = 1;
        cyc();
        perf_clear = 0;
        push("sat_clear", K_SC, 0);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_ctrl_sb.md
# hazard_ctrl_sb

Parametrised successor to the pipeline hazard unit for the 5-stage RISC-V core; sits beside the ID stage. Generates IF/ID and ID/EX stall, flush and ID-operand forwarding selects. Handles load-use and auipc (la) stalls with configurable lengths, and adds a per-register scoreboard for multi-cycle (MUL/DIV) results plus saturating stall/flush performance counters.

## Interface
- REG_AW, 5, register address width; the scoreboard has 2**REG_AW entries.
- LOAD_STALL, 1, total stall cycles for one load-use hazard (1..7).
- LA_STALL, 3, total stall cycles for one auipc-in-MEM event (1..7).
- CNT_W, 16, performance counter width.

- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rs1_ID, rs2_ID  in  REG_AW  source registers of the instruction in ID
- rs1_used_ID, rs2_used_ID  in  1  the corresponding source is actually read
- rd_EX  in  REG_AW; regwrite_EX  in  1; load_EX  in  1 (EX holds a load)
- rd_MEM  in  REG_AW; regwrite_MEM  in  1; auipc_MEM  in  1
- rd_WB  in  REG_AW; regwrite_WB  in  1
- branch_ID  in  1  branch in ID; branch_taken  in  1  branch resolved taken
- mc_issue  in  1; mc_rd  in  REG_AW  multi-cycle op leaves ID this cycle with destination mc_rd
- mc_done  in  1; mc_done_rd  in  REG_AW  multi-cycle result written back this cycle
- perf_clear  in  1  synchronous clear of both counters
- stall_IFID, stall_IDEX, flush  out  1
- fwd_rs1_sel, fwd_rs2_sel  out  2  00 regfile, 01 from MEM, 10 from WB
- stall_output  out  32  reason code
- stall_cycles, flush_count  out  CNT_W  saturating counters
- sb_busy  out  1  any scoreboard bit set

## Operation
- A match for a source means: the source is used, it equals the stage's rd, that stage's write enable is set, and rd != 0. x0 never creates a hazard and is never forwarded.
- Load-use detect (lu): an rs1 or rs2 match against rd_EX with load_EX=1.
- Scoreboard hit (sbh): a used, nonzero rs whose scoreboard bit is set.
- Stall counter (3 bits): on lu, load LOAD_STALL-1. On auipc_MEM, load LA_STALL-1; if both occur, load the larger value. Otherwise decrement toward 0. On branch_taken, clear to 0; flush overrides.
- Output priority (combinational; default outputs 0):
  - branch_taken: flush=1, code 0xF.
  - auipc_MEM: both stalls, code 0xA.
  - lu or counter>0: both stalls, code 0x1.
  - sbh: both stalls, code 0xC.
  - branch_ID: stall_IFID only, code 0xB.
- Scoreboard:
  - mc_issue sets bit mc_rd. mc_done clears bit mc_done_rd. Writes to index 0 are ignored.
  - If issue and done hit the same index in one cycle, set wins.
  - mc_issue asserted while flush=1 is ignored.
- Forwarding, per source: the MEM match has priority over the WB match. Otherwise the select is 00.
- stall_cycles increments on any cycle with stall_IFID|stall_IDEX. flush_count increments on flush. Both saturate at all-ones. perf_clear takes priority over increment.

## Timing
- Reset values: counter 0, scoreboard all 0, stall_cycles 0, flush_count 0. All combinational outputs are then 0 / code 0x0, given idle inputs.
- Stall, flush, forwarding and code outputs are combinational in the same cycle. State updates on the rising edge of clock.
- Isolated lu: exactly LOAD_STALL stall cycles, starting with the detect cycle. Isolated auipc_MEM pulse: exactly LA_STALL cycles.
- A new lu or auipc_MEM while the counter is running reloads the counter; the counter never adds to the remaining value.
- A scoreboard set is visible to sbh in the cycle after mc_issue. A clear releases the stall in the cycle after mc_done. No same-cycle bypass from mc_done.
- Reset asserted mid-stall immediately forces all state to 0, asynchronously.

## Test plan
- Reset, then idle inputs: all outputs 0, code 0x0, counters 0.
- LOAD_STALL=2; load_EX=1, rd_EX=5, rs1_ID=5 for one cycle -> both stalls for exactly 2 cycles, code 0x1, stall_cycles=2. Repeat with rd_EX=0 -> no stall.
- auipc_MEM pulse with LA_STALL=3 -> 3 stall cycles, code 0xA. Pulse branch_taken in the 2nd cycle -> flush, code 0xF, counter cleared, no stall afterwards, flush_count=1.
- mc_issue with mc_rd=7, then rs2_ID=7 used -> stall with code 0xC until the cycle after mc_done with mc_done_rd=7. Simultaneous issue and done on 7 -> bit stays set.
- rd_MEM=3 and rd_WB=3 both writing, rs1_ID=3 -> fwd_rs1_sel=01. Only WB writing -> 10. With rs1_used_ID=0 -> 00.
- CNT_W=4; hold a stall for 20 cycles -> stall_cycles saturates at 15. perf_clear -> 0 on the next cycle.
